// File: rtl/truth_table_checker.sv
// Truth-table sweep engine: drives all 16 minterms into a 4-input board, samples NF
// outputs after SETTLE cycles and records mismatches against a table latched at start.
module truth_table_checker #(
    parameter int NF     = 10,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [16*NF-1:0] exp_table,
    output logic [3:0]       dut_in,
    input  logic [NF-1:0]    dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [NF-1:0]    fail_mask,
    output logic [3:0]       first_fail_idx,
    output logic [3:0]       first_fail_func,
    output logic             first_fail_valid,
    output logic [16*NF-1:0] cap_table
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("truth_table_checker: SETTLE must be in 1..15");
        end
        if (NF < 1 || NF > 16) begin : g_bad_nf
            $error("truth_table_checker: NF must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       idx;
    logic [3:0]       cnt;
    logic [16*NF-1:0] exp_lat;
    logic [16*NF-1:0] cap_next;
    logic [NF-1:0]    mismatch;
    logic [3:0]       low_func;
    logic             sample_edge;
    logic             last_sample;

    // The applied vector is the minterm index itself; it holds 15 after a sweep.
    assign dut_in      = idx;
    assign sample_edge = (state == ST_SETTLE) && (cnt == CNT_LAST);
    assign last_sample = sample_edge && (idx == 4'd15);

    // Per-function compare at the current minterm; the descending loop leaves the
    // lowest mismatching function index in low_func.
    always_comb begin
        logic [15:0] exp_fld;
        logic [15:0] cap_fld;
        exp_fld  = '0;
        cap_fld  = '0;
        mismatch = '0;
        low_func = '0;
        cap_next = cap_table;
        for (int k = NF - 1; k >= 0; k--) begin
            exp_fld     = exp_lat[16*k +: 16];
            cap_fld     = cap_table[16*k +: 16];
            mismatch[k] = (dut_out[k] !== exp_fld[idx]);
            cap_fld[idx] = dut_out[k];
            cap_next[16*k +: 16] = cap_fld;
            if (mismatch[k]) begin
                low_func = 4'(k);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETTLE;
            ST_SETTLE: if (last_sample) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_mask        <= '0;
            first_fail_idx   <= '0;
            first_fail_func  <= '0;
            first_fail_valid <= 1'b0;
            cap_table        <= '0;
            exp_lat          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_lat          <= exp_table;
                        fail_mask        <= '0;
                        first_fail_idx   <= '0;
                        first_fail_func  <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        cap_table        <= '0;
                        idx              <= '0;
                        cnt              <= '0;
                        busy             <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (sample_edge) begin
                        cap_table <= cap_next;
                        fail_mask <= fail_mask | mismatch;
                        if (!first_fail_valid && (|mismatch)) begin
                            first_fail_idx   <= idx;
                            first_fail_func  <= low_func;
                            first_fail_valid <= 1'b1;
                        end
                        // pass must include this final compare, not just the registered mask.
                        if (idx == 4'd15) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= ~|(fail_mask | mismatch);
                        end else begin
                            idx <= idx + 4'd1;
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a behavioural board feeds two instances (SETTLE=3 and
// SETTLE=1); results are checked against a minterm-level model of the expected sweep.
module tb_truth_table_checker;

    localparam int NF     = 10;
    localparam int SETTLE = 3;
    localparam int W      = 16 * NF;
    localparam int CW     = 192;

    typedef logic [CW-1:0] cval_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          sel;
    logic [W-1:0]  exp_table;
    logic [15:0]   board_mask [NF];
    logic [15:0]   gold [NF];

    logic          start0, start1;
    logic [3:0]    dut_in0, dut_in1;
    logic [NF-1:0] dut_out0, dut_out1;
    logic          busy0, busy1, done0, done1, pass0, pass1;
    logic [NF-1:0] fail_mask0, fail_mask1;
    logic [3:0]    ffi0, ffi1, fff0, fff1;
    logic          ffv0, ffv1;
    logic [W-1:0]  cap0, cap1;

    logic          o_busy, o_done, o_pass, o_ffv;
    logic [3:0]    o_dut_in, o_ffi, o_fff;
    logic [NF-1:0] o_mask;
    logic [W-1:0]  o_cap;

    logic          m_pass, m_ffv;
    logic [3:0]    m_ffi, m_fff;
    logic [NF-1:0] m_mask;
    logic [W-1:0]  m_cap;

    int total = 0;
    int bad   = 0;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    truth_table_checker #(.NF(NF), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .exp_table(exp_table),
        .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_mask(fail_mask0), .first_fail_idx(ffi0),
        .first_fail_func(fff0), .first_fail_valid(ffv0), .cap_table(cap0)
    );

    truth_table_checker #(.NF(NF), .SETTLE(1)) u_dut_fast (
        .clk(clk), .rst(rst), .start(start1), .exp_table(exp_table),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_mask(fail_mask1), .first_fail_idx(ffi1),
        .first_fail_func(fff1), .first_fail_valid(ffv1), .cap_table(cap1)
    );

    // Board model: each function is a 16-entry lookup on the applied minterm.
    always_comb begin
        dut_out0 = '0;
        dut_out1 = '0;
        for (int k = 0; k < NF; k++) begin
            dut_out0[k] = board_mask[k][dut_in0];
            dut_out1[k] = board_mask[k][dut_in1];
        end
    end

    always_comb begin
        o_busy   = sel ? busy1      : busy0;
        o_done   = sel ? done1      : done0;
        o_pass   = sel ? pass1      : pass0;
        o_ffv    = sel ? ffv1       : ffv0;
        o_dut_in = sel ? dut_in1    : dut_in0;
        o_ffi    = sel ? ffi1       : ffi0;
        o_fff    = sel ? fff1       : fff0;
        o_mask   = sel ? fail_mask1 : fail_mask0;
        o_cap    = sel ? cap1       : cap0;
    end

    task automatic checkOutput(input string tag, input cval_t observed, input cval_t expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] goldTable();
        logic [W-1:0] t;
        t = '0;
        for (int k = 0; k < NF; k++) t[16*k +: 16] = gold[k];
        return t;
    endfunction

    // Expected results straight from the minterm rules: any differing bit fails its
    // function; the first failure is the lowest minterm, then the lowest function there.
    task automatic computeModel(input logic [W-1:0] exp_lat);
        logic [15:0] diff [NF];
        m_mask = '0;
        m_cap  = '0;
        m_ffv  = 1'b0;
        m_ffi  = '0;
        m_fff  = '0;
        for (int k = 0; k < NF; k++) begin
            diff[k]           = board_mask[k] ^ exp_lat[16*k +: 16];
            m_mask[k]         = |diff[k];
            m_cap[16*k +: 16] = board_mask[k];
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < NF; k++) begin
                if (diff[k][i] && !m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffi = 4'(i);
                    m_fff = 4'(k);
                end
            end
        end
        m_pass = (m_mask == '0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_rstctl"}, cval_t'({o_busy, o_done, o_pass, o_mask, o_ffi, o_fff, o_ffv, o_dut_in}), '0);
        checkOutput({name, "_rstcap"}, cval_t'(o_cap), '0);
    endtask

    // One sweep, checked every cycle for busy/done/dut_in, then the results against the model.
    task automatic applyStimulus(input string name, input bit fast, input int start_pulse_at,
                                 input int rst_at, input int change_at, input logic [W-1:0] exp_new);
        int s;
        bit aborted;
        logic exp_busy, exp_done;
        logic [3:0] exp_vec;
        s       = fast ? 1 : SETTLE;
        aborted = 1'b0;
        sel     = fast;
        @(negedge clk);
        start = 1'b1;
        computeModel(exp_table);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= 16 * s; j++) begin
            if (j > 0) begin
                @(negedge clk);
                start = 1'b0;
            end
            exp_busy = (j < 16 * s);
            exp_done = (j == 16 * s);
            exp_vec  = (j < 16 * s) ? 4'(j / s) : 4'd15;
            checkOutput($sformatf("%s_ctl_c%0d", name, j), cval_t'({o_busy, o_done, o_dut_in}),
                        cval_t'({exp_busy, exp_done, exp_vec}));
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkAllZero(name);
                @(negedge clk);
                checkOutput({name, "_postrst"}, cval_t'({o_busy, o_done, o_dut_in}), '0);
                aborted = 1'b1;
                break;
            end
            if (j == start_pulse_at) start = 1'b1;
            if (j == change_at) exp_table = exp_new;
        end
        if (!aborted) begin
            @(negedge clk);
            checkOutput({name, "_idle"}, cval_t'({o_busy, o_done, o_dut_in}), cval_t'({1'b0, 1'b0, 4'd15}));
            checkOutput({name, "_res"}, cval_t'({o_pass, o_mask, o_ffi, o_fff, o_ffv}),
                        cval_t'({m_pass, m_mask, m_ffi, m_fff, m_ffv}));
            checkOutput({name, "_cap"}, cval_t'(o_cap), cval_t'(m_cap));
        end
    endtask

    initial begin
        logic [W-1:0] exp_f4_zero;
        // f0=wx f1=parity f2=~z f3=xy|wz f4=yz f5=w|x f6=~w f7=~x f8=yz f9=x^y
        gold = '{16'hF000, 16'h6996, 16'h5555, 16'hEAC0, 16'h8888,
                 16'hFFF0, 16'h00FF, 16'h0F0F, 16'h8888, 16'h3C3C};
        board_mask = gold;
        exp_table  = goldTable();
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        sel = 1'b1;
        checkAllZero("reset_fast");
        sel = 1'b0;
        rst = 1'b0;

        $display("[TB] good board sweep");
        applyStimulus("good", 1'b0, -1, -1, -1, '0);
        checkOutput("good_pass", cval_t'({o_pass, o_mask}), cval_t'({1'b1, 10'h000}));
        checkOutput("good_cap_eq_exp", cval_t'(o_cap), cval_t'(exp_table));

        $display("[TB] f3 stuck-at-0");
        board_mask[3] = 16'h0000;
        applyStimulus("f3sa0", 1'b0, -1, -1, -1, '0);
        checkOutput("f3sa0_direct", cval_t'({o_pass, o_mask, o_ffi, o_fff, o_ffv}),
                    cval_t'({1'b0, 10'h008, 4'd6, 4'd3, 1'b1}));

        $display("[TB] f4 and f8 inverted");
        board_mask    = gold;
        board_mask[4] = ~gold[4];
        board_mask[8] = ~gold[8];
        applyStimulus("f4f8inv", 1'b0, -1, -1, -1, '0);
        checkOutput("f4f8inv_direct", cval_t'({o_mask, o_ffi, o_fff}), cval_t'({10'h110, 4'd0, 4'd4}));

        $display("[TB] start pulse mid-sweep and reset abort");
        board_mask = gold;
        applyStimulus("midstart", 1'b0, 10, -1, -1, '0);
        applyStimulus("abort", 1'b0, -1, 20, -1, '0);
        applyStimulus("fresh", 1'b0, -1, -1, -1, '0);

        $display("[TB] expected table latched at start");
        exp_f4_zero = goldTable();
        exp_f4_zero[16*4 +: 16] = 16'h0000;
        applyStimulus("latch", 1'b0, -1, -1, 20, exp_f4_zero);
        checkOutput("latch_pass", cval_t'(o_pass), cval_t'(1'b1));
        applyStimulus("newtbl", 1'b0, -1, -1, -1, '0);
        checkOutput("newtbl_direct", cval_t'({o_mask, o_ffi, o_fff}), cval_t'({10'h010, 4'd3, 4'd4}));
        exp_table = goldTable();

        $display("[TB] SETTLE=1 instance");
        applyStimulus("fast_good", 1'b1, -1, -1, -1, '0);
        checkOutput("fast_pass", cval_t'(o_pass), cval_t'(1'b1));

        $display("[TB] random board faults");
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NF; k++) begin
                board_mask[k] = gold[k] ^ (($urandom_range(0, 2) == 0) ?
                                (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0000);
            end
            applyStimulus($sformatf("rand%0d", r), (r % 3) == 2, -1, -1, -1, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
